alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

- Register-file and sequencing stage that sits directly upstream of the 8-bit ALU (a/b/alu_ctrl → result/zero).
- Accepts one instruction at a time over a valid/ready handshake, reads two source operands from an internal register file, and drives the ALU operand and control ports from registers.
- Captures the ALU result and zero flag, writes the result back to the destination register and pulses `done`.
- Also supports a load-immediate instruction, so software and benches can seed the register file.

## Interface
Parameters:
- DATA_W, 8, datapath width; must match the ALU
- REG_CNT, 4, number of registers; address width AW = clog2(REG_CNT) = 2

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  high only in IDLE
- instr_ldi  in  1  1 = load immediate, 0 = ALU op
- instr_op  in  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 SLT
- instr_rd, instr_rs1, instr_rs2  in  AW each  destination and source register indices
- instr_imm  in  DATA_W  immediate for LDI
- alu_a, alu_b  out  DATA_W  registered ALU operands
- alu_ctrl  out  3  registered ALU op
- alu_result  in  DATA_W  ALU result (combinational from ALU)
- alu_zero  in  1  ALU zero flag
- done  out  1  one-cycle pulse per completed write-back
- wb_data  out  DATA_W  value last written to the register file
- zero_flag  out  1  zero status of last write-back; holds its value until the next write-back
- dbg_addr  in  AW  debug read address (only with ALU_SEQ_DBG_EN)
- dbg_data  out  DATA_W  combinational rf[dbg_addr] (only with ALU_SEQ_DBG_EN)

## Operation
- FSM states: IDLE, EXEC, WB. Edges are named E0 (accept), E1 and E2.
- Accept: at edge E0, when state is IDLE and instr_valid is 1.
  - All instruction fields are latched at E0; later changes to the inputs are ignored.
- ALU op, E0:
  - alu_a ← rf[rs1], alu_b ← rf[rs2], alu_ctrl ← instr_op.
  - rd is latched; state ← EXEC.
- ALU op, E1:
  - res_q ← alu_result, z_q ← alu_zero.
  - state ← WB.
- ALU op, E2:
  - rf[rd] ← res_q, wb_data ← res_q, zero_flag ← z_q.
  - done ← 1; state ← IDLE.
- LDI, E0:
  - res_q ← instr_imm, z_q ← (instr_imm == 0).
  - state ← WB; alu_a, alu_b and alu_ctrl are left unchanged.
  - At E1 the WB actions above apply.
- rd equal to rs1 or rs2 is legal: sources are read at E0, before the write-back.
- The ALU result is truncated to DATA_W. No carry or overflow is kept.
- Reset values:
  - state IDLE.
  - All rf entries 0.
  - alu_a, alu_b, alu_ctrl, res_q, z_q, wb_data: 0.
  - zero_flag 0, done 0.
  - instr_ready is 1 once rst_n deasserts.

## Timing
- instr_ready is combinational and equals (state == IDLE).
- ALU op latency: accept at E0 → done high in the cycle after E2, i.e. 3 cycles.
  - Maximum throughput is one ALU op per 3 cycles.
- LDI latency: done high in the cycle after E1, i.e. 2 cycles.
- done is high for exactly one cycle.
  - A new instruction may be accepted on the same edge that clears done.
- The ALU path is treated as single-cycle: alu_result is sampled one full cycle after alu_a, alu_b and alu_ctrl are registered.
- If instr_valid stays high while busy, no instruction is accepted, dropped or duplicated. The instruction is taken at the first IDLE edge.
- rst_n assertion in any state (including mid EXEC or WB) takes effect immediately:
  - state returns to IDLE and all registers clear;
  - the aborted instruction is not written back and produces no done.

## Configuration
- ALU_SEQ_DBG_EN defined: the dbg_addr and dbg_data ports exist; dbg_data = rf[dbg_addr] combinationally.
- ALU_SEQ_DBG_EN undefined: both ports are absent. Write-back results remain visible on wb_data only.

## Structure
- Shared package alu_pkg holds:
  - the ALU op encoding constants (ADD through SLT);
  - the FSM state typedef;
  - the DATA_W default.
- One sub-module, regfile_nx8:
  - REG_CNT entries;
  - two combinational read ports plus the debug read port;
  - one synchronous write port;
  - asynchronous clear on rst_n.

## Test plan
- Reset: hold rst_n=0, then release → instr_ready=1; done=0, alu_a=alu_b=0, alu_ctrl=000, wb_data=0, zero_flag=0; every register reads 0.
- LDI r1=10, then LDI r2=5 → each gives done 2 cycles after accept; wb_data=10, then 5; with ALU_SEQ_DBG_EN, dbg r1=10 and r2=5.
- ADD r3=r1+r2 (ALU model attached) → one cycle after accept: alu_a=10, alu_b=5, alu_ctrl=000; done 3 cycles after accept with wb_data=15, zero_flag=0; rf[3]=15.
- SUB r0=r1-r1 → wb_data=0, zero_flag=1; then LDI r0=7 → zero_flag=0.
- Hold instr_valid=1 with 3 back-to-back ops → instr_ready low in EXEC and WB; exactly 3 done pulses, spaced 3 cycles apart, results in order.
- Assert rst_n in the EXEC cycle of ADD r3=r1+r2 → no done; rf all 0; instr_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing stage: op encodings, FSM state type,
// default datapath width.
package alu_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } seq_state_t;

endpackage

// File: rtl/regfile_nx8.sv
// REG_CNT x DATA_W register file: two combinational read ports, one synchronous
// write port, async clear. Debug read port exists only with ALU_SEQ_DBG_EN.
module regfile_nx8 #(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 4,
    parameter int AW      = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd
`ifdef ALU_SEQ_DBG_EN
    ,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
`endif
);

    logic [DATA_W-1:0] rf [REG_CNT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf <= '{default: '0};
        end else if (we) begin
            rf[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = rf[ra1];
        rd2 = rf[ra2];
    end

`ifdef ALU_SEQ_DBG_EN
    always_comb begin
        dbg_data = rf[dbg_addr];
    end
`endif

endmodule

// File: rtl/alu_op_sequencer.sv
// Register-file and sequencing stage feeding an external single-cycle ALU.
// Optional debug read port enabled by defining ALU_SEQ_DBG_EN.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_CNT = 4,
    localparam int AW     = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              instr_ldi,
    input  logic [2:0]        instr_op,
    input  logic [AW-1:0]     instr_rd,
    input  logic [AW-1:0]     instr_rs1,
    input  logic [AW-1:0]     instr_rs2,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              done,
    output logic [DATA_W-1:0] wb_data,
    output logic              zero_flag
`ifdef ALU_SEQ_DBG_EN
    ,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
`endif
);

    seq_state_t        state_q, state_d;
    logic              accept;
    logic              rf_we;
    logic [AW-1:0]     rd_q;
    logic [DATA_W-1:0] res_q;
    logic              z_q;
    logic [DATA_W-1:0] rs1_data, rs2_data;

    regfile_nx8 #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT),
        .AW      (AW)
    ) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra1      (instr_rs1),
        .ra2      (instr_rs2),
        .rd1      (rs1_data),
        .rd2      (rs2_data),
        .we       (rf_we),
        .wa       (rd_q),
        .wd       (res_q)
`ifdef ALU_SEQ_DBG_EN
        ,
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (instr_valid) state_d = instr_ldi ? ST_WB : ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state_q == ST_IDLE);
        accept      = instr_ready && instr_valid;
        rf_we       = (state_q == ST_WB);
    end

    // LDI bypasses EXEC by loading res_q/z_q directly at accept; ALU operands keep their old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q      <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= '0;
            res_q     <= '0;
            z_q       <= 1'b0;
            wb_data   <= '0;
            zero_flag <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= rf_we;
            if (accept) begin
                rd_q <= instr_rd;
                if (instr_ldi) begin
                    res_q <= instr_imm;
                    z_q   <= (instr_imm == '0);
                end else begin
                    alu_a    <= rs1_data;
                    alu_b    <= rs2_data;
                    alu_ctrl <= instr_op;
                end
            end
            if (state_q == ST_EXEC) begin
                res_q <= alu_result;
                z_q   <= alu_zero;
            end
            if (rf_we) begin
                wb_data   <= res_q;
                zero_flag <= z_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 8-bit ALU attached.
// Debug-port checks are compiled in only when ALU_SEQ_DBG_EN is defined.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic       instr_ldi = 1'b0;
    logic [2:0] instr_op = '0;
    logic [1:0] instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
    logic [7:0] instr_imm = '0;
    logic [7:0] alu_a, alu_b, alu_result, wb_data;
    logic [2:0] alu_ctrl;
    logic       alu_zero, done, zero_flag;
`ifdef ALU_SEQ_DBG_EN
    logic [1:0] dbg_addr = '0;
    logic [7:0] dbg_data;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] cap_a, cap_b;
    logic [2:0] cap_ctrl;
    int         lat;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DATA_W(8), .REG_CNT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_ldi   (instr_ldi),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .instr_imm   (instr_imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .done        (done),
        .wb_data     (wb_data),
        .zero_flag   (zero_flag)
`ifdef ALU_SEQ_DBG_EN
        ,
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
`endif
    );

    // Stand-in for the downstream ALU
    always_comb begin
        case (alu_ctrl)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_SHL:  alu_result = alu_a << alu_b[2:0];
            OP_SHR:  alu_result = alu_a >> alu_b[2:0];
            default: alu_result = {7'd0, (alu_a < alu_b)};
        endcase
        alu_zero = (alu_result == 8'd0);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic present(input logic ldi, input logic [2:0] op, input logic [1:0] rd,
                           input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm);
        instr_ldi = ldi;
        instr_op  = op;
        instr_rd  = rd;
        instr_rs1 = rs1;
        instr_rs2 = rs2;
        instr_imm = imm;
    endtask

    // Issues one instruction, then scrambles the inputs to prove they were latched.
    // Returns with the clock at the negedge where done is high (lat = cycles since accept, 0 = none).
    task automatic issue(input logic ldi, input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm);
        int w;
        @(negedge clk);
        w = 0;
        while (!instr_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        present(ldi, op, rd, rs1, rs2, imm);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        present(~ldi, ~op, ~rd, ~rs1, ~rs2, ~imm);
        cap_a    = alu_a;
        cap_b    = alu_b;
        cap_ctrl = alu_ctrl;
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    logic [1:0] b_rd  [3] = '{2'd0, 2'd2, 2'd1};
    logic [1:0] b_rs1 [3] = '{2'd1, 2'd1, 2'd1};
    logic [1:0] b_rs2 [3] = '{2'd2, 2'd2, 2'd3};
    logic [2:0] b_op  [3] = '{OP_AND, OP_OR, OP_XOR};
    logic [7:0] b_exp [3] = '{8'd0, 8'd15, 8'd5};
    logic [7:0] b_res [3];
    int         b_cyc [3];

    initial begin
        int idx, nd, lows, npulse;
        logic prev_ready;

        // Reset
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ready",  instr_ready, 1);
        check_eq("rst_done",   done, 0);
        check_eq("rst_alu_a",  alu_a, 0);
        check_eq("rst_alu_b",  alu_b, 0);
        check_eq("rst_ctrl",   alu_ctrl, 0);
        check_eq("rst_wb",     wb_data, 0);
        check_eq("rst_zero",   zero_flag, 0);
`ifdef ALU_SEQ_DBG_EN
        for (int r = 0; r < 4; r++) begin
            dbg_addr = 2'(r);
            #1 check_eq("rst_rf", dbg_data, 0);
        end
`endif

        // LDI r1=10, LDI r2=5
        issue(1'b1, OP_ADD, 2'd1, 2'd0, 2'd0, 8'd10);
        check_eq("ldi1_lat",  lat, 2);
        check_eq("ldi1_wb",   wb_data, 10);
        check_eq("ldi1_zero", zero_flag, 0);
        check_eq("ldi1_alu_a_kept", cap_a, 0);
        issue(1'b1, OP_ADD, 2'd2, 2'd0, 2'd0, 8'd5);
        check_eq("ldi2_lat",  lat, 2);
        check_eq("ldi2_wb",   wb_data, 5);
`ifdef ALU_SEQ_DBG_EN
        dbg_addr = 2'd1;
        #1 check_eq("dbg_r1", dbg_data, 10);
        dbg_addr = 2'd2;
        #1 check_eq("dbg_r2", dbg_data, 5);
`endif

        // ADD r3 = r1 + r2
        issue(1'b0, OP_ADD, 2'd3, 2'd1, 2'd2, 8'd0);
        check_eq("add_alu_a", cap_a, 10);
        check_eq("add_alu_b", cap_b, 5);
        check_eq("add_ctrl",  cap_ctrl, 0);
        check_eq("add_lat",   lat, 3);
        check_eq("add_wb",    wb_data, 15);
        check_eq("add_zero",  zero_flag, 0);
        @(negedge clk);
        check_eq("done_pulse", done, 0);
        check_eq("zero_hold", zero_flag, 0);
`ifdef ALU_SEQ_DBG_EN
        dbg_addr = 2'd3;
        #1 check_eq("dbg_r3", dbg_data, 15);
`endif

        // SUB r0 = r1 - r1, then LDI r0 = 7
        issue(1'b0, OP_SUB, 2'd0, 2'd1, 2'd1, 8'd0);
        check_eq("sub_wb",   wb_data, 0);
        check_eq("sub_zero", zero_flag, 1);
        issue(1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 8'd7);
        check_eq("ldi0_wb",   wb_data, 7);
        check_eq("ldi0_zero", zero_flag, 0);

        // rd == rs: r3 = r3 - r0 = 15 - 7
        issue(1'b0, OP_SUB, 2'd3, 2'd3, 2'd0, 8'd0);
        check_eq("rdrs_wb", wb_data, 8);
        issue(1'b0, OP_ADD, 2'd3, 2'd1, 2'd2, 8'd0);
        check_eq("restore_wb", wb_data, 15);

        // Three ops with instr_valid held high
        @(negedge clk);
        present(1'b0, b_op[0], b_rd[0], b_rs1[0], b_rs2[0], 8'd0);
        instr_valid = 1'b1;
        prev_ready = instr_ready;
        idx = 0; nd = 0; lows = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (prev_ready && instr_valid) begin
                idx++;
                if (idx < 3) present(1'b0, b_op[idx], b_rd[idx], b_rs1[idx], b_rs2[idx], 8'd0);
                else instr_valid = 1'b0;
            end
            if (!instr_ready) lows++;
            if (done) begin
                if (nd < 3) begin
                    b_res[nd] = wb_data;
                    b_cyc[nd] = cyc;
                end
                nd++;
            end
            prev_ready = instr_ready;
        end
        instr_valid = 1'b0;
        check_eq("b2b_count", nd, 3);
        check_eq("b2b_busy_cycles", lows, 6);
        for (int k = 0; k < 3; k++) check_eq("b2b_result", b_res[k], b_exp[k]);
        check_eq("b2b_first_lat", b_cyc[0], 3);
        check_eq("b2b_space1", b_cyc[1] - b_cyc[0], 3);
        check_eq("b2b_space2", b_cyc[2] - b_cyc[1], 3);

        // Reset during EXEC of ADD r3 = r1 + r2
        @(negedge clk);
        present(1'b0, OP_ADD, 2'd3, 2'd1, 2'd2, 8'd0);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1 check_eq("abort_ready_in_rst", instr_ready, 1);
        npulse = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) npulse++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done) npulse++;
        end
        check_eq("abort_no_done", npulse, 0);
        check_eq("abort_ready",   instr_ready, 1);
        check_eq("abort_wb",      wb_data, 0);
        check_eq("abort_alu_a",   alu_a, 0);
`ifdef ALU_SEQ_DBG_EN
        for (int r = 0; r < 4; r++) begin
            dbg_addr = 2'(r);
            #1 check_eq("abort_rf", dbg_data, 0);
        end
`endif
        // Cleared registers: r1 + r2 must now be zero
        issue(1'b0, OP_ADD, 2'd3, 2'd1, 2'd2, 8'd0);
        check_eq("post_abort_a",    cap_a, 0);
        check_eq("post_abort_b",    cap_b, 0);
        check_eq("post_abort_lat",  lat, 3);
        check_eq("post_abort_wb",   wb_data, 0);
        check_eq("post_abort_zero", zero_flag, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
